// File: rtl/config_frame_fsm_if.sv
// Word-level bus between the serial receiver, the config frame parser and the fabric frame writer.
// write_strobe is a one-cycle valid with no ready: the parser accepts every strobed word.
interface config_frame_fsm_if;
  logic        write_strobe;
  logic [31:0] write_data;
  logic        active;
  logic [31:0] frame_data;
  logic        frame_strobe;
  logic [7:0]  frame_col;
  logic [7:0]  frame_index;
  logic [15:0] word_index;
  logic        config_done;
  logic        busy;
  logic        error;
  logic [1:0]  state_dbg;

  modport master (
    output write_strobe, write_data, active,
    input  frame_data, frame_strobe, frame_col, frame_index, word_index,
           config_done, busy, error, state_dbg
  );

  modport slave (
    input  write_strobe, write_data, active,
    output frame_data, frame_strobe, frame_col, frame_index, word_index,
           config_done, busy, error, state_dbg
  );
endinterface

// File: rtl/config_frame_fsm.sv
// Configuration word parser: sync lock, header decode, addressed frame-data writes.
// Optional per-frame checksum word enabled by defining CONFIG_FRAME_CHECKSUM_EN.
module config_frame_fsm #(
  parameter logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1,
  parameter int unsigned MAX_FRAMES = 20,
  parameter logic [7:0]  END_COL    = 8'hFF
) (
  input logic            clk,
  input logic            reset,
  config_frame_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2
`ifdef CONFIG_FRAME_CHECKSUM_EN
    , S_CHECK = 2'd3
`endif
  } state_t;

  // Widened so a MAX_FRAMES above 255 simply accepts every 8-bit index.
  localparam logic [8:0] MAX_IDX = (MAX_FRAMES > 255) ? 9'd256 : 9'(MAX_FRAMES);

  state_t      state_q, state_n;
  logic [31:0] frame_data_q, frame_data_n;
  logic        frame_strobe_q, frame_strobe_n;
  logic [7:0]  frame_col_q, frame_col_n;
  logic [7:0]  frame_index_q, frame_index_n;
  logic [15:0] word_index_q, word_index_n;
  logic        config_done_q, config_done_n;
  logic        error_q, error_n;
  logic [15:0] remaining_q, remaining_n;
  logic [15:0] counter_q, counter_n;
`ifdef CONFIG_FRAME_CHECKSUM_EN
  logic [31:0] acc_q, acc_n;
`endif

  logic [7:0]  hdr_col;
  logic [7:0]  hdr_idx;
  logic [15:0] hdr_count;
  logic        is_sync;

  assign hdr_col   = bus.write_data[31:24];
  assign hdr_idx   = bus.write_data[23:16];
  assign hdr_count = bus.write_data[15:0];
  assign is_sync   = (bus.write_data == SYNC_WORD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      frame_data_q   <= '0;
      frame_strobe_q <= 1'b0;
      frame_col_q    <= '0;
      frame_index_q  <= '0;
      word_index_q   <= '0;
      config_done_q  <= 1'b0;
      error_q        <= 1'b0;
      remaining_q    <= '0;
      counter_q      <= '0;
`ifdef CONFIG_FRAME_CHECKSUM_EN
      acc_q          <= '0;
`endif
    end else begin
      state_q        <= state_n;
      frame_data_q   <= frame_data_n;
      frame_strobe_q <= frame_strobe_n;
      frame_col_q    <= frame_col_n;
      frame_index_q  <= frame_index_n;
      word_index_q   <= word_index_n;
      config_done_q  <= config_done_n;
      error_q        <= error_n;
      remaining_q    <= remaining_n;
      counter_q      <= counter_n;
`ifdef CONFIG_FRAME_CHECKSUM_EN
      acc_q          <= acc_n;
`endif
    end
  end

  always_comb begin
    state_n        = state_q;
    frame_data_n   = frame_data_q;
    frame_strobe_n = 1'b0;
    frame_col_n    = frame_col_q;
    frame_index_n  = frame_index_q;
    word_index_n   = word_index_q;
    config_done_n  = 1'b0;
    error_n        = error_q;
    remaining_n    = remaining_q;
    counter_n      = counter_q;
`ifdef CONFIG_FRAME_CHECKSUM_EN
    acc_n          = acc_q;
`endif

    // Losing the session wins over any coincident word; the partial frame is dropped.
    if (!bus.active) begin
      state_n = S_IDLE;
    end else if (bus.write_strobe) begin
      case (state_q)
        S_IDLE: begin
          if (is_sync) begin
            state_n = S_HEADER;
            error_n = 1'b0;
          end
        end
        S_HEADER: begin
          if (is_sync) begin
            state_n = S_HEADER;
          end else if (hdr_col == END_COL) begin
            config_done_n = 1'b1;
            state_n       = S_IDLE;
          end else if ({1'b0, hdr_idx} >= MAX_IDX) begin
            error_n = 1'b1;
            state_n = S_IDLE;
          end else if (hdr_count != 16'd0) begin
            frame_col_n   = hdr_col;
            frame_index_n = hdr_idx;
            remaining_n   = hdr_count;
            counter_n     = 16'd0;
            state_n       = S_DATA;
`ifdef CONFIG_FRAME_CHECKSUM_EN
            acc_n         = bus.write_data;
`endif
          end
        end
        S_DATA: begin
          frame_data_n   = bus.write_data;
          word_index_n   = counter_q;
          frame_strobe_n = 1'b1;
          counter_n      = counter_q + 16'd1;
          remaining_n    = remaining_q - 16'd1;
`ifdef CONFIG_FRAME_CHECKSUM_EN
          acc_n          = acc_q + bus.write_data;
          if (remaining_q == 16'd1) state_n = S_CHECK;
`else
          if (remaining_q == 16'd1) state_n = S_HEADER;
`endif
        end
`ifdef CONFIG_FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (bus.write_data == acc_q) begin
            state_n = S_HEADER;
          end else begin
            error_n = 1'b1;
            state_n = S_IDLE;
          end
        end
`endif
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.frame_data   = frame_data_q;
  assign bus.frame_strobe = frame_strobe_q;
  assign bus.frame_col    = frame_col_q;
  assign bus.frame_index  = frame_index_q;
  assign bus.word_index   = word_index_q;
  assign bus.config_done  = config_done_q;
  assign bus.error        = error_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_config_frame_fsm.sv
// Directed bench for config_frame_fsm: each scenario task drives words and checks outputs inline.
module tb_config_frame_fsm;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_q[$];

  config_frame_fsm_if bus();

  config_frame_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one strobed word; returns at the falling edge after the capturing rising edge.
  task automatic send(input logic [31:0] w);
    @(negedge clk);
    bus.write_data   = w;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.active = 1'b0;
    bus.write_strobe = 1'b0;
    bus.write_data = '0;
    idle(3);
    vectors++; if (bus.frame_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_frame_strobe: got %0h want 0", bus.frame_strobe); end
    vectors++; if (bus.frame_data !== 32'h0) begin miscompares++; $display("FAIL reset_frame_data: got %0h want 0", bus.frame_data); end
    vectors++; if ({bus.frame_col, bus.frame_index, bus.word_index} !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %0h want 0", {bus.frame_col, bus.frame_index, bus.word_index}); end
    vectors++; if ({bus.config_done, bus.busy, bus.error} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {bus.config_done, bus.busy, bus.error}); end
    vectors++; if (bus.state_dbg !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
    reset = 1'b0;
    bus.active = 1'b1;
    send(32'h0305_0003);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_ignore: busy got %0h want 0", bus.busy); end
  endtask

  task automatic test_basic_frame();
    send(32'hFAB0_FAB1);
    vectors++; if (bus.state_dbg !== 2'd1) begin miscompares++; $display("FAIL sync_header: state got %0d want 1", bus.state_dbg); end
    send(32'h0305_0003);
    vectors++; if (bus.state_dbg !== 2'd2) begin miscompares++; $display("FAIL hdr_data: state got %0d want 2", bus.state_dbg); end
    vectors++; if (bus.frame_strobe !== 1'b0) begin miscompares++; $display("FAIL hdr_no_strobe: got %0h want 0", bus.frame_strobe); end
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    exp_q.push_back(32'hC);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] w;
      w = exp_q.pop_front();
      send(w);
      vectors++; if (bus.frame_strobe !== 1'b1) begin miscompares++; $display("FAIL basic_strobe[%0d]: got %0h want 1", i, bus.frame_strobe); end
      vectors++; if (bus.frame_data !== w) begin miscompares++; $display("FAIL basic_data[%0d]: got %0h want %0h", i, bus.frame_data, w); end
      vectors++; if (bus.word_index !== 16'(i)) begin miscompares++; $display("FAIL basic_word_index[%0d]: got %0d want %0d", i, bus.word_index, i); end
      vectors++; if ({bus.frame_col, bus.frame_index} !== 16'h0305) begin miscompares++; $display("FAIL basic_addr[%0d]: got %0h want 0305", i, {bus.frame_col, bus.frame_index}); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy[%0d]: got %0h want 1", i, bus.busy); end
    end
    idle(1);
    vectors++; if (bus.frame_strobe !== 1'b0) begin miscompares++; $display("FAIL basic_single_pulse: got %0h want 0", bus.frame_strobe); end
    vectors++; if (bus.frame_data !== 32'hC) begin miscompares++; $display("FAIL basic_hold: got %0h want c", bus.frame_data); end
`ifdef CONFIG_FRAME_CHECKSUM_EN
    send(32'h0305_0024);
    vectors++; if (bus.frame_strobe !== 1'b0) begin miscompares++; $display("FAIL basic_chk_no_strobe: got %0h want 0", bus.frame_strobe); end
`endif
    vectors++; if (bus.state_dbg !== 2'd1) begin miscompares++; $display("FAIL basic_end_header: state got %0d want 1", bus.state_dbg); end
  endtask

  task automatic test_back_to_back();
    send(32'h0400_0001);
    send(32'h0000_0055);
    vectors++; if (bus.frame_strobe !== 1'b1) begin miscompares++; $display("FAIL b2b_strobe: got %0h want 1", bus.frame_strobe); end
    vectors++; if ({bus.frame_col, bus.frame_index, bus.word_index} !== 32'h0400_0000) begin miscompares++; $display("FAIL b2b_addr: got %0h want 04000000", {bus.frame_col, bus.frame_index, bus.word_index}); end
    vectors++; if (bus.frame_data !== 32'h55) begin miscompares++; $display("FAIL b2b_data: got %0h want 55", bus.frame_data); end
`ifdef CONFIG_FRAME_CHECKSUM_EN
    send(32'h0400_0056);
`endif
  endtask

  task automatic test_error_paths();
    send(32'hFAB0_FAB1);
    vectors++; if (bus.state_dbg !== 2'd1) begin miscompares++; $display("FAIL resync_header: state got %0d want 1", bus.state_dbg); end
    send(32'h0114_0001);
    vectors++; if ({bus.error, bus.busy} !== 2'b10) begin miscompares++; $display("FAIL idx20_error: err,busy got %b want 10", {bus.error, bus.busy}); end
    send(32'hFAB0_FAB1);
    vectors++; if ({bus.error, bus.busy} !== 2'b01) begin miscompares++; $display("FAIL sync_clears_error: err,busy got %b want 01", {bus.error, bus.busy}); end
    send(32'h0200_0000);
    vectors++; if ({bus.state_dbg, bus.frame_strobe} !== 3'b010) begin miscompares++; $display("FAIL count_zero: state,strobe got %b want 010", {bus.state_dbg, bus.frame_strobe}); end
    send(32'h0113_0002);
    vectors++; if (bus.state_dbg !== 2'd2) begin miscompares++; $display("FAIL idx19_accept: state got %0d want 2", bus.state_dbg); end
    send(32'hFAB0_FAB1);
    vectors++; if ({bus.frame_strobe, bus.frame_data} !== {1'b1, 32'hFAB0_FAB1}) begin miscompares++; $display("FAIL sync_as_data: got %0h want 1fab0fab1", {bus.frame_strobe, bus.frame_data}); end
    send(32'h0000_0099);
    vectors++; if ({bus.frame_index, bus.word_index} !== 24'h13_0001) begin miscompares++; $display("FAIL idx19_addr: got %0h want 130001", {bus.frame_index, bus.word_index}); end
`ifdef CONFIG_FRAME_CHECKSUM_EN
    send(32'hFBC3_FB4C);
`endif
    send(32'hFF00_0000);
    vectors++; if ({bus.config_done, bus.busy} !== 2'b10) begin miscompares++; $display("FAIL end_col: done,busy got %b want 10", {bus.config_done, bus.busy}); end
    idle(1);
    vectors++; if (bus.config_done !== 1'b0) begin miscompares++; $display("FAIL done_single_pulse: got %0h want 0", bus.config_done); end
  endtask

  task automatic test_abort();
    send(32'hFAB0_FAB1);
    send(32'h0305_0003);
    send(32'h0000_0001);
    vectors++; if (bus.frame_strobe !== 1'b1) begin miscompares++; $display("FAIL abort_first: got %0h want 1", bus.frame_strobe); end
    @(negedge clk);
    bus.write_data   = 32'h0000_0002;
    bus.write_strobe = 1'b1;
    bus.active       = 1'b0;
    @(negedge clk);
    bus.write_strobe = 1'b0;
    bus.active       = 1'b1;
    vectors++; if (bus.frame_strobe !== 1'b0) begin miscompares++; $display("FAIL abort_no_strobe: got %0h want 0", bus.frame_strobe); end
    vectors++; if ({bus.state_dbg, bus.busy, bus.error} !== 4'b0000) begin miscompares++; $display("FAIL abort_idle: state,busy,err got %b want 0000", {bus.state_dbg, bus.busy, bus.error}); end
    vectors++; if (bus.frame_data !== 32'h1) begin miscompares++; $display("FAIL abort_hold: got %0h want 1", bus.frame_data); end
    send(32'h0000_0003);
    vectors++; if ({bus.frame_strobe, bus.busy} !== 2'b00) begin miscompares++; $display("FAIL abort_ignore: strobe,busy got %b want 00", {bus.frame_strobe, bus.busy}); end
  endtask

  task automatic test_reset_mid_data();
    send(32'hFAB0_FAB1);
    send(32'h0305_0003);
    send(32'h0000_000A);
    #2 reset = 1'b1;
    #1;
    vectors++; if ({bus.frame_strobe, bus.frame_data, bus.frame_col, bus.frame_index, bus.word_index} !== 65'h0) begin miscompares++; $display("FAIL midreset_outputs: got %0h want 0", {bus.frame_strobe, bus.frame_data, bus.frame_col, bus.frame_index, bus.word_index}); end
    vectors++; if ({bus.state_dbg, bus.busy} !== 3'b000) begin miscompares++; $display("FAIL midreset_state: got %b want 000", {bus.state_dbg, bus.busy}); end
    @(negedge clk);
    reset = 1'b0;
    send(32'h0000_000B);
    vectors++; if ({bus.frame_strobe, bus.busy} !== 2'b00) begin miscompares++; $display("FAIL midreset_ignore: strobe,busy got %b want 00", {bus.frame_strobe, bus.busy}); end
  endtask

`ifdef CONFIG_FRAME_CHECKSUM_EN
  task automatic test_checksum();
    send(32'hFAB0_FAB1);
    send(32'h0001_0002);
    send(32'h0000_0001);
    send(32'h0000_0002);
    vectors++; if (bus.state_dbg !== 2'd3) begin miscompares++; $display("FAIL chk_state: got %0d want 3", bus.state_dbg); end
    send(32'h0001_0005);
    vectors++; if ({bus.state_dbg, bus.error, bus.frame_strobe} !== 4'b0100) begin miscompares++; $display("FAIL chk_match: state,err,strobe got %b want 0100", {bus.state_dbg, bus.error, bus.frame_strobe}); end
    send(32'h0001_0002);
    send(32'h0000_0001);
    send(32'h0000_0002);
    send(32'h0001_0006);
    vectors++; if ({bus.error, bus.busy} !== 2'b10) begin miscompares++; $display("FAIL chk_mismatch: err,busy got %b want 10", {bus.error, bus.busy}); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_error_paths();
    test_abort();
    test_reset_mid_data();
`ifdef CONFIG_FRAME_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/config_frame_fsm.md
Name: config_frame_fsm

Overview:
Word-level configuration parser directly downstream of the serial bit-bang receiver. Consumes its one-cycle word strobe, 32-bit word and active flag. Locks on a sync word, decodes frame headers and emits addressed frame-data writes toward the fabric frame/row registers. Also signals end of configuration and protocol errors.

Parameters:
SYNC_WORD, 32'hFAB0_FAB1, word that arms the parser from IDLE
MAX_FRAMES, 20, frame_index values >= this are rejected
END_COL, 8'hFF, header column value meaning "configuration complete"

Ports:
clk  input  1  system clock; all logic rising-edge
reset  input  1  asynchronous, active-high reset
write_strobe  input  1  one-cycle word-valid pulse from upstream receiver
write_data  input  32  configuration word, valid when write_strobe=1
active  input  1  upstream session flag; low forces parser idle
frame_data  output  32  data word being written
frame_strobe  output  1  one-cycle write pulse for frame_data
frame_col  output  8  column address of current frame
frame_index  output  8  frame number within column
word_index  output  16  position of frame_data within the frame, 0-based
config_done  output  1  one-cycle pulse on END_COL header
busy  output  1  high whenever state != IDLE
error  output  1  sticky protocol error flag

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; internal counters 0.
- Only cycles with write_strobe=1 advance the parser; other cycles hold state.
- IDLE:
  - strobe with write_data==SYNC_WORD -> HEADER; error cleared.
  - Any other word is ignored.
- HEADER: strobe decodes col=[31:24], idx=[23:16], count=[15:0].
  - write_data==SYNC_WORD: stay in HEADER (resync, no-op).
  - col==END_COL: pulse config_done the next cycle, go to IDLE.
  - idx>=MAX_FRAMES: set error, go to IDLE.
  - count==0: stay in HEADER, no writes.
  - Otherwise: latch col/idx into frame_col/frame_index, load remaining=count, word counter=0, go to DATA.
- DATA: each strobe registers frame_data<=write_data and word_index<=counter, and pulses frame_strobe.
  - All of these are valid the cycle after the input strobe (latency 1).
  - Counter increments; remaining decrements.
  - On the strobe where remaining==1 -> HEADER (a new header is accepted without resync).
  - SYNC_WORD inside DATA is treated as data.
- active low in any cycle: state -> IDLE next edge.
  - The partial frame is abandoned; no frame_strobe for a coincident write_strobe.
  - error is unchanged.
  - active low takes priority over a simultaneous strobe.
- frame_strobe and config_done are never high for two consecutive cycles from one input strobe.
- frame_col, frame_index, frame_data and word_index hold their last value between strobes.
- count=16'hFFFF is legal; word_index reaches 65534 with no wrap issue.
- error clears only on reset or a SYNC_WORD accepted in IDLE.

Optional Feature:
CONFIG_FRAME_CHECKSUM_EN
- Defined:
  - After the last DATA word, the parser enters state CHECK and expects one more word.
  - That word must equal the modulo-2^32 sum of the header word and all data words of the frame.
  - Match -> HEADER. Mismatch -> set error, go to IDLE.
  - The checksum word itself produces no frame_strobe.
  - The accumulator is reset at each accepted header.
- Not defined: no CHECK state and no accumulator logic; DATA goes straight to HEADER.

Test Plan:
- Reset mid-DATA: assert reset during DATA -> all outputs 0 immediately, state IDLE; the next data word without sync is ignored.
- Basic frame:
  - Stimulus: FAB0_FAB1, then header 0x0305_0003, then data 0xA, 0xB, 0xC.
  - Response: three frame_strobe pulses, each one cycle after its input strobe.
  - frame_col=3, frame_index=5, word_index=0,1,2, frame_data=0xA/0xB/0xC; busy=1 throughout.
- Back-to-back frames: after the frame above, header 0x0400_0001 plus data 0x55 without resync -> frame_col=4, frame_index=0, word_index=0, frame_data=0x55.
- Error and end paths:
  - Header with idx=0x14 (20) -> error=1, busy=0.
  - A following FAB0_FAB1 -> error=0.
  - Header 0xFF00_0000 -> single config_done pulse, busy=0.
- Abort: drop active after 1 of 3 data words, coincident with a strobe -> no further frame_strobe; state IDLE.
- Checksum (macro on):
  - Header 0x0001_0002, data 1, 2, checksum 0x0001_0005 -> returns to HEADER, error=0.
  - Same frame with checksum 0x0001_0006 -> error=1, IDLE.
